// File: rtl/popcount_pattern_gen.sv
// Weight-class pattern generator: for a requested weight k, emits every N-bit
// vector with exactly k ones in ascending order over a valid/ready stream.
module popcount_pattern_gen #(
  parameter int N  = 4,
  parameter int WW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [WW-1:0] weight,
  output logic          busy,
  output logic [N-1:0]  out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last,
  output logic [15:0]   out_count,
  output logic          done,
  output logic          err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_HOLD = 2'd2,
    ST_FIN  = 2'd3
  } state_t;

  localparam logic [WW-1:0] N_W      = WW'(N);
  localparam logic [N-1:0]  ALL_ONES = {N{1'b1}};
  localparam logic [N-1:0]  ONE_N    = {{(N-1){1'b0}}, 1'b1};
  localparam logic [15:0]   ONE_16   = 16'd1;

  function automatic logic [WW-1:0] popcount(input logic [N-1:0] v);
    logic [WW-1:0] s;
    s = {WW{1'b0}};
    for (int i = 0; i < N; i++) begin
      s = s + WW'(v[i]);
    end
    return s;
  endfunction

  // k ones packed at the MSB end; zero when k is zero
  function automatic logic [N-1:0] last_pattern(input logic [WW-1:0] k);
    logic [N-1:0] res;
    res = {N{1'b0}};
    for (int i = 0; i < N; i++) begin
      res[i] = (i >= (N - int'(k)));
    end
    return res;
  endfunction

  state_t         r_state, w_state_nxt;
  logic [WW-1:0]  r_kreg, w_kreg_nxt;
  logic [N-1:0]   r_cand, w_cand_nxt;
  logic           r_prime, w_prime_nxt;
  logic [N-1:0]   r_data, w_data_nxt;
  logic           r_valid, w_valid_nxt;
  logic           r_last, w_last_nxt;
  logic [15:0]    r_count, w_count_nxt;
  logic           r_busy, w_busy_nxt;
  logic           r_done, w_done_nxt;
  logic           r_err, w_err_nxt;

  logic [WW-1:0]  w_pc;
  logic [N-1:0]   w_lastpat;
  logic           w_hs;

  assign w_pc      = popcount(r_cand);
  assign w_lastpat = last_pattern(r_kreg);
  assign w_hs      = r_valid & out_ready;

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_kreg  <= {WW{1'b0}};
      r_cand  <= {N{1'b0}};
      r_prime <= 1'b0;
      r_data  <= {N{1'b0}};
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_count <= 16'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_kreg  <= w_kreg_nxt;
      r_cand  <= w_cand_nxt;
      r_prime <= w_prime_nxt;
      r_data  <= w_data_nxt;
      r_valid <= w_valid_nxt;
      r_last  <= w_last_nxt;
      r_count <= w_count_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // Next-state and next-output logic for the scan engine
  always_comb begin
    w_state_nxt = r_state;
    w_kreg_nxt  = r_kreg;
    w_cand_nxt  = r_cand;
    w_prime_nxt = r_prime;
    w_data_nxt  = r_data;
    w_valid_nxt = r_valid;
    w_last_nxt  = r_last;
    w_count_nxt = r_count;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_busy_nxt  = 1'b1;
          w_count_nxt = 16'd0;
          if (weight > N_W) begin
            w_state_nxt = ST_FIN;
            w_done_nxt  = 1'b1;
            w_err_nxt   = 1'b1;
          end else begin
            w_state_nxt = ST_SCAN;
            w_kreg_nxt  = weight;
            w_cand_nxt  = {N{1'b0}};
            w_prime_nxt = 1'b1;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end

      ST_SCAN: begin
        // First SCAN cycle only settles; the compare never sees the raw weight input
        if (r_prime) begin
          w_prime_nxt = 1'b0;
        end else if (w_pc == r_kreg) begin
          w_data_nxt  = r_cand;
          w_valid_nxt = 1'b1;
          w_last_nxt  = (r_cand == w_lastpat);
          w_state_nxt = ST_HOLD;
        end else if (r_cand == ALL_ONES) begin
          w_state_nxt = ST_FIN;
          w_done_nxt  = 1'b1;
        end else begin
          w_cand_nxt = r_cand + ONE_N;
        end
      end

      ST_HOLD: begin
        if (w_hs) begin
          w_count_nxt = r_count + ONE_16;
          w_valid_nxt = 1'b0;
          w_last_nxt  = 1'b0;
          if (r_last) begin
            w_state_nxt = ST_FIN;
            w_done_nxt  = 1'b1;
          end else begin
            w_cand_nxt  = r_cand + ONE_N;
            w_state_nxt = ST_SCAN;
          end
        end else begin
          w_state_nxt = ST_HOLD;
        end
      end

      ST_FIN: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = ST_IDLE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_valid_nxt = 1'b0;
        w_last_nxt  = 1'b0;
        w_busy_nxt  = 1'b0;
        w_prime_nxt = 1'b0;
      end
    endcase
  end

  assign busy      = r_busy;
  assign out_data  = r_data;
  assign out_valid = r_valid;
  assign out_last  = r_last;
  assign out_count = r_count;
  assign done      = r_done;
  assign err       = r_err;

endmodule

// File: doc/popcount_pattern_gen.md
Name: popcount_pattern_gen

Overview:
- Inverse of the team's 4-bit popcount block: given a requested weight k, enumerates every N-bit vector with exactly k ones.
- Patterns are emitted in ascending numeric order over a valid/ready stream.
- Used to drive exhaustive weight-class stimulus and to generate codewords for the popcount datapath.
- Sequential scan engine with output hold buffer and completion/error signalling.

Parameters:
- N, 4, pattern width in bits (2..16)
- WW, $clog2(N+1), width of weight and count fields

Ports:
- clk  input  1  rising-edge clock; the block's only clock
- rst_n  input  1  synchronous active-low reset, sampled on rising clk
- start  input  1  request pulse; accepted only in IDLE
- weight  input  WW  requested number of ones; latched on accepted start
- busy  output  1  high from cycle after accepted start until return to IDLE
- out_data  output  N  current pattern
- out_valid  output  1  out_data holds a valid pattern
- out_ready  input  1  downstream accepts pattern when out_valid and out_ready both high
- out_last  output  1  high with the final pattern of the sequence
- out_count  output  16  number of patterns already accepted in this run
- done  output  1  one-cycle pulse when the run ends
- err  output  1  one-cycle pulse coincident with done when weight > N

Behaviour:
- Reset values (rst_n low at a clk edge): state IDLE; busy, out_valid, out_last, done, err = 0; out_data = 0; out_count = 0; candidate register = 0.
- Reset applies mid-run: sequence aborted, no done pulse.
- States are IDLE, SCAN, HOLD, FIN. All outputs are registered.
- IDLE:
  - start=1 and weight<=N at edge t: latch weight into kreg, cand<=0, out_count<=0; SCAN at t+1, busy=1.
  - start=1 and weight>N: FIN with err flagged; no patterns emitted.
  - start ignored in every state except IDLE.
- SCAN (one candidate per cycle):
  - popcount(cand)==kreg: out_data<=cand; out_valid<=1; out_last<=(cand==LASTPAT); go HOLD.
  - Else, if cand==2^N-1: go FIN (unreachable for legal k; defensive only).
  - Else: cand<=cand+1.
- LASTPAT = ((1<<kreg)-1) << (N-kreg), i.e. the k ones packed at the MSBs. For k=0, LASTPAT=0.
- HOLD:
  - out_data, out_valid and out_last are stable until handshake.
  - out_ready may be high before out_valid; no combinational ready-to-valid path exists.
  - On handshake: out_count<=out_count+1; out_valid<=0; out_last<=0.
  - After handshake, if the pattern was the last one, go FIN; else cand<=cand+1 and go SCAN.
- FIN: done=1 for exactly one cycle; err=1 in that same cycle iff the weight>N path was taken; busy<=0; go IDLE.
- A new start is accepted in the cycle after FIN. out_data and out_count retain their final values in IDLE.
- Latency:
  - Accepted start at edge t gives first out_valid at edge t+1+(first matching candidate)+1. For k=0 this is t+2.
  - Between patterns: handshake edge, then one cycle per non-matching candidate, then one cycle to load.
- Throughput is at most one pattern per 2 cycles; no back-to-back streaming is required.
- Popcount is a combinational sum over cand bits, width WW, with no overflow.
- The candidate counter is N bits; it never wraps because the scan ends at LASTPAT.

Test Plan:
- N=4, weight=2, out_ready tied 1 -> stream 0x3,0x5,0x6,0x9,0xA,0xC; out_last only on 0xC; done one cycle after the 0xC handshake; out_count=6.
- N=4, weight=0 -> single pattern 0x0 with out_last=1, first out_valid exactly 2 cycles after start; weight=4 -> single pattern 0xF, out_last=1, out_count=1.
- N=4, weight=5 -> no out_valid ever; done=1 and err=1 in the same single cycle; busy returns to 0; out_count=0.
- N=4, weight=1, random out_ready backpressure -> 0x1,0x2,0x4,0x8 each held stable while stalled; no drop or duplicate; start pulses while busy are ignored.
- N=4, weight=3, rst_n driven low after the second handshake -> next cycle all outputs are 0, state IDLE, no done; a fresh start with weight=3 yields 0x7,0xB,0xD,0xE.
- N=4, weights 0..4 run sequentially -> pattern counts 1,4,6,4,1 (total 16); every emitted pattern's popcount equals the requested weight.
